// File: rtl/axi_sram_traffic_gen.sv
// AXI4 burst traffic generator/checker (write, read, write-then-verify) with saturating run statistics.
// One burst in flight; AW/AR valid one cycle after start; fully stalls on slave ready/valid, never back-pressures R or B.
module axi_sram_traffic_gen #(
   parameter int AXI_ADDR_WIDTH  = 18,
   parameter int AXI_DATA_WIDTH  = 16,
   parameter int BURST_LEN       = 8,
   parameter int BURST_CNT_WIDTH = 16,
   parameter int STAT_WIDTH      = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [1:0]                 mode,
   input  logic [AXI_ADDR_WIDTH-1:0]  base_addr,
   input  logic [BURST_CNT_WIDTH-1:0] num_bursts,
   output logic                       busy,
   output logic                       done,
   output logic [STAT_WIDTH-1:0]      cycle_count,
   output logic [STAT_WIDTH-1:0]      beat_count,
   output logic [STAT_WIDTH-1:0]      err_count,
   output logic                       m_axi_awvalid,
   input  logic                       m_axi_awready,
   output logic [AXI_ADDR_WIDTH-1:0]  m_axi_awaddr,
   output logic [7:0]                 m_axi_awlen,
   output logic                       m_axi_wvalid,
   input  logic                       m_axi_wready,
   output logic [AXI_DATA_WIDTH-1:0]  m_axi_wdata,
   output logic                       m_axi_wlast,
   input  logic                       m_axi_bvalid,
   output logic                       m_axi_bready,
   output logic                       m_axi_arvalid,
   input  logic                       m_axi_arready,
   output logic [AXI_ADDR_WIDTH-1:0]  m_axi_araddr,
   output logic [7:0]                 m_axi_arlen,
   input  logic                       m_axi_rvalid,
   output logic                       m_axi_rready,
   input  logic [AXI_DATA_WIDTH-1:0]  m_axi_rdata,
   input  logic                       m_axi_rlast
);
   localparam int BYTES = AXI_DATA_WIDTH / 8;
   localparam int LOG2B = $clog2(BYTES);
   localparam logic [AXI_ADDR_WIDTH-1:0] STRIDE = AXI_ADDR_WIDTH'(BURST_LEN * BYTES);
   localparam logic [8:0] LAST_BEAT = 9'(BURST_LEN - 1);
   localparam logic [7:0] AXLEN     = 8'(BURST_LEN - 1);

   typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

   state_t                     state;
   logic                       verify_q;
   logic [AXI_ADDR_WIDTH-1:0]  base_q;
   logic [AXI_ADDR_WIDTH-1:0]  burst_addr;
   logic [BURST_CNT_WIDTH-1:0] num_q;
   logic [BURST_CNT_WIDTH-1:0] burst_idx;
   logic [8:0]                 beat;
   logic                       last_burst;
   logic [AXI_ADDR_WIDTH-1:0]  next_addr;
   logic                       data_err;
   logic                       last_err;
   logic [1:0]                 r_err_n;

   // Pattern word is the beat's byte address in units of bus words, truncated to the bus width.
   function automatic logic [AXI_DATA_WIDTH-1:0] pattern(input logic [AXI_ADDR_WIDTH-1:0] a,
                                                          input logic [8:0] b);
      logic [AXI_ADDR_WIDTH-1:0] beat_addr;
      beat_addr = a + (AXI_ADDR_WIDTH'(b) << LOG2B);
      return AXI_DATA_WIDTH'(beat_addr >> LOG2B);
   endfunction

   function automatic logic [STAT_WIDTH-1:0] sat_add(input logic [STAT_WIDTH-1:0] v,
                                                      input logic [1:0] n);
      logic [STAT_WIDTH:0] s;
      s = {1'b0, v} + (STAT_WIDTH+1)'(n);
      return s[STAT_WIDTH] ? '1 : s[STAT_WIDTH-1:0];
   endfunction

   assign last_burst  = (burst_idx == num_q - BURST_CNT_WIDTH'(1));
   assign next_addr   = burst_addr + STRIDE;
   assign data_err    = (m_axi_rdata != pattern(burst_addr, beat));
   assign last_err    = (m_axi_rlast != (beat == LAST_BEAT));
   assign r_err_n     = {1'b0, data_err} + {1'b0, last_err};
   assign m_axi_awlen = m_axi_awvalid ? AXLEN : 8'd0;
   assign m_axi_arlen = m_axi_arvalid ? AXLEN : 8'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         verify_q <= 1'b0;
         base_q <= '0;
         burst_addr <= '0;
         num_q <= '0;
         burst_idx <= '0;
         beat <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         cycle_count <= '0;
         beat_count <= '0;
         err_count <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_awaddr <= '0;
         m_axi_wvalid <= 1'b0;
         m_axi_wdata <= '0;
         m_axi_wlast <= 1'b0;
         m_axi_bready <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_araddr <= '0;
         m_axi_rready <= 1'b0;
      end else begin
         // The DONE cycle is excluded so the counts are final while done is high.
         if (busy && state != S_DONE) cycle_count <= sat_add(cycle_count, 2'd1);
         case (state)
            S_IDLE: if (start) begin
               busy <= 1'b1;
               verify_q <= mode[1];
               base_q <= base_addr;
               num_q <= num_bursts;
               burst_idx <= '0;
               burst_addr <= base_addr;
               beat <= '0;
               cycle_count <= '0;
               beat_count <= '0;
               err_count <= '0;
               if (num_bursts == '0) begin
                  state <= S_DONE;
                  done <= 1'b1;
               end else if (mode == 2'b01) begin
                  state <= S_AR;
                  m_axi_arvalid <= 1'b1;
                  m_axi_araddr <= base_addr;
               end else begin
                  state <= S_AW;
                  m_axi_awvalid <= 1'b1;
                  m_axi_awaddr <= base_addr;
               end
            end
            S_AW: if (m_axi_awready) begin
               m_axi_awvalid <= 1'b0;
               m_axi_wvalid <= 1'b1;
               m_axi_wdata <= pattern(burst_addr, 9'd0);
               m_axi_wlast <= (LAST_BEAT == 9'd0);
               beat <= '0;
               state <= S_W;
            end
            S_W: if (m_axi_wready) begin
               beat_count <= sat_add(beat_count, 2'd1);
               if (beat == LAST_BEAT) begin
                  m_axi_wvalid <= 1'b0;
                  m_axi_wlast <= 1'b0;
                  m_axi_bready <= 1'b1;
                  state <= S_B;
               end else begin
                  beat <= beat + 9'd1;
                  m_axi_wdata <= pattern(burst_addr, beat + 9'd1);
                  m_axi_wlast <= (beat + 9'd1 == LAST_BEAT);
               end
            end
            S_B: if (m_axi_bvalid) begin
               m_axi_bready <= 1'b0;
               beat <= '0;
               if (!last_burst) begin
                  burst_idx <= burst_idx + BURST_CNT_WIDTH'(1);
                  burst_addr <= next_addr;
                  m_axi_awaddr <= next_addr;
                  m_axi_awvalid <= 1'b1;
                  state <= S_AW;
               end else if (verify_q) begin
                  burst_idx <= '0;
                  burst_addr <= base_q;
                  m_axi_araddr <= base_q;
                  m_axi_arvalid <= 1'b1;
                  state <= S_AR;
               end else begin
                  done <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_AR: if (m_axi_arready) begin
               m_axi_arvalid <= 1'b0;
               m_axi_rready <= 1'b1;
               beat <= '0;
               state <= S_R;
            end
            S_R: if (m_axi_rvalid) begin
               beat_count <= sat_add(beat_count, 2'd1);
               err_count <= sat_add(err_count, r_err_n);
               if (beat == LAST_BEAT) begin
                  m_axi_rready <= 1'b0;
                  beat <= '0;
                  if (last_burst) begin
                     done <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     burst_idx <= burst_idx + BURST_CNT_WIDTH'(1);
                     burst_addr <= next_addr;
                     m_axi_araddr <= next_addr;
                     m_axi_arvalid <= 1'b1;
                     state <= S_AR;
                  end
               end else begin
                  beat <= beat + 9'd1;
               end
            end
            S_DONE: begin
               done <= 1'b0;
               busy <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_sram_traffic_gen.sv
// Bench for axi_sram_traffic_gen: randomized AXI slave with word memory, queue scoreboard, run-level stats checks.
module tb_axi_sram_traffic_gen;
   localparam int AW = 18, DW = 16, BL = 8, BCW = 16, SW = 16;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [1:0] mode = '0;
   logic [AW-1:0] base_addr = '0;
   logic [BCW-1:0] num_bursts = '0;
   logic busy, done;
   logic [SW-1:0] cycle_count, beat_count, err_count;
   logic m_axi_awvalid, m_axi_awready = 1'b0;
   logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
   logic [7:0] m_axi_awlen, m_axi_arlen;
   logic m_axi_wvalid, m_axi_wready = 1'b0, m_axi_wlast;
   logic [DW-1:0] m_axi_wdata;
   logic m_axi_bvalid = 1'b0, m_axi_bready;
   logic m_axi_arvalid, m_axi_arready = 1'b0;
   logic m_axi_rvalid = 1'b0, m_axi_rready, m_axi_rlast = 1'b0;
   logic [DW-1:0] m_axi_rdata = '0;

   always #5 clk = ~clk;

   axi_sram_traffic_gen #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .BURST_LEN(BL),
                          .BURST_CNT_WIDTH(BCW), .STAT_WIDTH(SW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
      .num_bursts(num_bursts), .busy(busy), .done(done), .cycle_count(cycle_count),
      .beat_count(beat_count), .err_count(err_count),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
      .m_axi_awlen(m_axi_awlen), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wlast(m_axi_wlast), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_rvalid(m_axi_rvalid),
      .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast));

   int checks = 0, failures = 0;
   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed { logic last; logic [DW-1:0] data; } wbeat_t;
   typedef struct { int beats; int errs; } stat_t;
   logic [AW-1:0] exp_aw[$], exp_ar[$];
   wbeat_t exp_w[$];
   stat_t exp_st[$];
   logic [DW-1:0] mem[int];
   int cyc = 0, start_cyc = 0, done_seen = 0, runs = 0, stall_pct = 0;

   always @(posedge clk) cyc++;

   // Reference: byte address of the idx-th beat of a run, modulo the address space.
   function automatic logic [AW-1:0] byte_addr(input logic [AW-1:0] base, input int idx);
      longint a;
      a = longint'(base) + longint'(idx) * (DW / 8);
      return AW'(a % (longint'(1) << AW));
   endfunction
   function automatic int word_of(input logic [AW-1:0] a);
      return int'(a) / (DW / 8);
   endfunction
   function automatic logic [DW-1:0] pat(input int w);
      return DW'(w);
   endfunction
   function automatic logic [DW-1:0] rd_mem(input int w);
      return mem.exists(w) ? mem[w] : '0;
   endfunction

   task automatic prepare(input logic [1:0] md, input logic [AW-1:0] base, input int nb);
      bit do_wr, do_rd;
      int beats, errs, w;
      wbeat_t wb;
      stat_t st;
      do_wr = (md != 2'b01);
      do_rd = (md != 2'b00);
      beats = 0;
      errs = 0;
      if (do_wr)
         for (int k = 0; k < nb; k++) begin
            exp_aw.push_back(byte_addr(base, k * BL));
            for (int j = 0; j < BL; j++) begin
               w = word_of(byte_addr(base, k * BL + j));
               wb.last = (j == BL - 1);
               wb.data = pat(w);
               exp_w.push_back(wb);
               beats++;
            end
         end
      if (do_rd)
         for (int k = 0; k < nb; k++) begin
            exp_ar.push_back(byte_addr(base, k * BL));
            for (int j = 0; j < BL; j++) begin
               w = word_of(byte_addr(base, k * BL + j));
               if (!do_wr && rd_mem(w) != pat(w)) errs++;
               beats++;
            end
         end
      st.beats = beats;
      st.errs = errs;
      exp_st.push_back(st);
   endtask

   task automatic launch(input logic [1:0] md, input logic [AW-1:0] base, input int nb);
      @(negedge clk);
      start_cyc = cyc + 1;
      mode = md;
      base_addr = base;
      num_bursts = BCW'(nb);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mode = 2'($urandom);
      base_addr = AW'($urandom);
      num_bursts = BCW'($urandom);
      chk("busy_after_start", busy, 1);
      if (nb == 0) chk("done_next_cycle", done, 1);
      else if (md == 2'b01) chk("arvalid_after_start", m_axi_arvalid, 1);
      else chk("awvalid_after_start", m_axi_awvalid, 1);
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      runs++;
      while (done_seen < runs && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("run_completed", done_seen >= runs, 1);
      @(negedge clk);
      chk("busy_low_after_done", busy, 0);
      chk("done_single_pulse", done, 0);
      chk("aw_queue_drained", exp_aw.size(), 0);
      chk("w_queue_drained", exp_w.size(), 0);
      chk("ar_queue_drained", exp_ar.size(), 0);
   endtask

   task automatic run(input logic [1:0] md, input logic [AW-1:0] base, input int nb, input int stall);
      stall_pct = stall;
      prepare(md, base, nb);
      launch(md, base, nb);
      wait_done(4000);
   endtask

   // Run-end monitor: compare statistics whenever done is presented.
   always @(negedge clk) begin : done_mon
      stat_t e;
      if (rst_n && done) begin
         done_seen++;
         if (exp_st.size() == 0) chk("unexpected_done", 1, 0);
         else begin
            e = exp_st.pop_front();
            chk("beat_count", beat_count, e.beats);
            chk("err_count", err_count, e.errs);
            chk("cycle_count", cycle_count, cyc - start_cyc);
            chk("busy_with_done", busy, 1);
         end
      end
   end

   // Slave with random stalls; handshakes are decided at the negedge before the edge that takes them.
   bit b_pend, hs_b, hs_r, w_open, aw_hold, w_hold;
   int w_beat, r_beat, r_left;
   logic [AW-1:0] w_addr, r_addr, aw_hold_addr;
   wbeat_t w_hold_dat;
   function automatic bit go();
      return ($urandom_range(99) >= stall_pct);
   endfunction

   always @(negedge clk) begin : slave
      wbeat_t e;
      if (!rst_n) begin
         m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
         m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rdata = '0;
         b_pend = 0; hs_b = 0; hs_r = 0; w_open = 0; aw_hold = 0; w_hold = 0;
         w_beat = 0; r_beat = 0; r_left = 0;
      end else begin
         if (hs_b) m_axi_bvalid = 1'b0;
         if (hs_r) m_axi_rvalid = 1'b0;
         hs_b = 0;
         hs_r = 0;
         m_axi_awready = go();
         m_axi_wready = go();
         m_axi_arready = go();
         if (!m_axi_bvalid && b_pend && go()) m_axi_bvalid = 1'b1;
         if (!m_axi_rvalid && r_left > 0 && go()) begin
            m_axi_rvalid = 1'b1;
            m_axi_rdata = rd_mem(word_of(byte_addr(r_addr, r_beat)));
            m_axi_rlast = (r_beat == BL - 1);
         end
         if (aw_hold) begin
            chk("aw_valid_held", m_axi_awvalid, 1);
            chk("aw_addr_held", m_axi_awaddr, aw_hold_addr);
         end
         if (w_hold) begin
            chk("w_valid_held", m_axi_wvalid, 1);
            chk("w_data_held", m_axi_wdata, w_hold_dat.data);
            chk("w_last_held", m_axi_wlast, w_hold_dat.last);
         end
         aw_hold = m_axi_awvalid && !m_axi_awready;
         aw_hold_addr = m_axi_awaddr;
         w_hold = m_axi_wvalid && !m_axi_wready;
         w_hold_dat.data = m_axi_wdata;
         w_hold_dat.last = m_axi_wlast;
         if (m_axi_awvalid && m_axi_awready) begin
            chk("awlen", m_axi_awlen, BL - 1);
            if (exp_aw.size() == 0) chk("unexpected_aw", 1, 0);
            else chk("awaddr", m_axi_awaddr, exp_aw.pop_front());
            w_addr = m_axi_awaddr;
            w_beat = 0;
            w_open = 1;
         end
         if (m_axi_wvalid && m_axi_wready) begin
            chk("w_after_aw", w_open, 1);
            if (exp_w.size() == 0) chk("unexpected_w", 1, 0);
            else begin
               e = exp_w.pop_front();
               chk("wdata", m_axi_wdata, e.data);
               chk("wlast", m_axi_wlast, e.last);
            end
            mem[word_of(byte_addr(w_addr, w_beat))] = m_axi_wdata;
            w_beat++;
            if (w_beat == BL) begin
               b_pend = 1;
               w_open = 0;
            end
         end
         if (m_axi_bvalid && m_axi_bready) begin
            hs_b = 1;
            b_pend = 0;
         end
         if (m_axi_arvalid && m_axi_arready) begin
            chk("arlen", m_axi_arlen, BL - 1);
            if (exp_ar.size() == 0) chk("unexpected_ar", 1, 0);
            else chk("araddr", m_axi_araddr, exp_ar.pop_front());
            r_addr = m_axi_araddr;
            r_beat = 0;
            r_left = BL;
         end
         if (m_axi_rvalid && m_axi_rready) begin
            hs_r = 1;
            r_beat++;
            r_left--;
         end
      end
   end

   initial begin
      #600000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      int n;
      logic [1:0] md;
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_awvalid", m_axi_awvalid, 0);
      chk("rst_arvalid", m_axi_arvalid, 0);
      chk("rst_rready", m_axi_rready, 0);
      chk("rst_stats", {cycle_count, beat_count, err_count}, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;

      run(2'b00, 18'h00100, 2, 0);
      run(2'b10, 18'h00400, 4, 0);
      mem[word_of(18'h00402)] ^= 16'h0040;
      run(2'b01, 18'h00400, 4, 0);
      run(2'b01, 18'h00400, 4, 45);
      run(2'b11, 18'h3FFF0, 3, 30);
      run(2'b00, 18'h00000, 0, 0);

      // A second start during a run must not disturb it.
      stall_pct = 40;
      prepare(2'b10, 18'h00800, 4);
      launch(2'b10, 18'h00800, 4);
      repeat (2) @(negedge clk);
      mode = 2'b01;
      num_bursts = 16'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(4000);

      for (int i = 0; i < 5; i++) begin
         md = 2'($urandom_range(3));
         run(md, AW'($urandom) & ~AW'(15), $urandom_range(1, 5), $urandom_range(0, 60));
      end

      // Asynchronous reset in the middle of a write burst.
      stall_pct = 50;
      prepare(2'b00, 18'h02000, 3);
      launch(2'b00, 18'h02000, 3);
      n = 0;
      while (!m_axi_wvalid && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("reached_w_phase", m_axi_wvalid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_wvalid", m_axi_wvalid, 0);
      chk("arst_wlast_wdata", {m_axi_wlast, m_axi_wdata}, 0);
      chk("arst_aw", {m_axi_awvalid, m_axi_awaddr, m_axi_awlen}, 0);
      chk("arst_ar", {m_axi_arvalid, m_axi_araddr, m_axi_arlen}, 0);
      chk("arst_readies", {m_axi_bready, m_axi_rready}, 0);
      chk("arst_busy_done", {busy, done}, 0);
      chk("arst_stats", {cycle_count, beat_count, err_count}, 0);
      exp_aw.delete();
      exp_w.delete();
      exp_ar.delete();
      exp_st.delete();
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      run(2'b10, 18'h02000, 2, 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
